// File: rtl/vga_cell_capture.sv
// Recovers raster position from TinyVGA syncs and samples the centre pixel
// of each 8x8 cell in the 512x256 board rectangle, once per locked frame.
module vga_cell_capture #(
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC_START = 656,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC_START = 490
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  vga_in,
  output logic        cell_valid,
  output logic [10:0] cell_index,
  output logic        cell_alive,
  output logic        frame_done,
  output logic [11:0] live_count,
  output logic        locked,
  output logic        sync_err
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
  localparam logic [9:0] V_SS   = 10'(V_SYNC_START);

  typedef enum logic [1:0] {
    HUNT,
    LINE,
    LOCKED
  } state_t;

  state_t      state, state_nx;
  logic [9:0]  hpos, vpos;
  logic [9:0]  cur_h, cur_v;
  logic [9:0]  h_nx, v_nx;
  logic        prev_hs, prev_vs;
  logic        capture;
  logic [11:0] count;

  logic hs, vs, hfall, vfall;
  logic h_bad, v_bad, err;
  logic wrap_h, frame_start;
  logic in_win, sample, last, alive;

  assign hs     = vga_in[7];
  assign vs     = vga_in[3];
  assign hfall  = prev_hs & ~hs;
  assign vfall  = prev_vs & ~vs;
  assign alive  = vga_in[0] & vga_in[1];
  assign locked = (state == LOCKED);

  assign h_bad = (hfall && hpos != H_SS) || (hpos == H_SS && hs);
  assign v_bad = vfall && (vpos != V_SS || hpos != 10'd0);

  always_comb begin
    state_nx = state;
    cur_h    = hpos;
    cur_v    = vpos;
    err      = 1'b0;
    unique case (state)
      HUNT: begin
        if (hfall) begin
          cur_h    = H_SS;
          state_nx = LINE;
        end
      end
      LINE: begin
        if (h_bad) begin
          err      = 1'b1;
          state_nx = HUNT;
        end else if (vfall && hpos == 10'd0) begin
          cur_v    = V_SS;
          state_nx = LOCKED;
        end
      end
      LOCKED: begin
        if (h_bad || v_bad) begin
          err      = 1'b1;
          state_nx = HUNT;
        end
      end
      default: state_nx = HUNT;
    endcase
  end

  always_comb begin
    wrap_h      = (cur_h == H_LAST);
    h_nx        = wrap_h ? 10'd0 : cur_h + 10'd1;
    v_nx        = cur_v;
    if (wrap_h)
      v_nx = (cur_v == V_LAST) ? 10'd0 : cur_v + 10'd1;
    frame_start = wrap_h && (cur_v == V_LAST);
    in_win      = cur_h >= 10'd64  && cur_h < 10'd576 &&
                  cur_v >= 10'd112 && cur_v < 10'd368 &&
                  cur_h[2:0] == 3'd3 && cur_v[2:0] == 3'd3;
    sample      = locked && !err && capture && in_win;
    last        = sample && cur_h == 10'd571 && cur_v == 10'd363;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      hpos       <= '0;
      vpos       <= '0;
      prev_hs    <= 1'b1;
      prev_vs    <= 1'b1;
      capture    <= 1'b0;
      count      <= '0;
      cell_valid <= 1'b0;
      cell_index <= '0;
      cell_alive <= 1'b0;
      frame_done <= 1'b0;
      live_count <= '0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      hpos       <= h_nx;
      vpos       <= v_nx;
      prev_hs    <= hs;
      prev_vs    <= vs;
      sync_err   <= err;
      cell_valid <= sample;
      cell_alive <= sample & alive;
      frame_done <= last;
      if (sample)
        cell_index <= {cur_v[7:3], cur_h[8:3]};
      if (last)
        live_count <= count + {11'd0, alive};
      // The frame in progress at lock time is partial and never captured.
      if (state_nx != LOCKED)
        capture <= 1'b0;
      else if (locked && frame_start)
        capture <= 1'b1;
      if (state_nx != LOCKED || last)
        count <= '0;
      else if (sample)
        count <= count + {11'd0, alive};
    end
  end

endmodule

// File: tb/tb_vga_cell_capture.sv
// Directed bench for vga_cell_capture: synthetic raster with a compact
// timing so each frame stays short while covering the full board window.
module tb_vga_cell_capture;

  localparam int HT = 592;
  localparam int HS = 580;
  localparam int HE = 588;
  localparam int VT = 370;
  localparam int VS = 368;
  localparam int VE = 370;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  vga_in = 8'hff;
  logic        cell_valid;
  logic [10:0] cell_index;
  logic        cell_alive;
  logic        frame_done;
  logic [11:0] live_count;
  logic        locked;
  logic        sync_err;

  vga_cell_capture #(
    .H_TOTAL(HT),
    .H_SYNC_START(HS),
    .V_TOTAL(VT),
    .V_SYNC_START(VS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vga_in(vga_in),
    .cell_valid(cell_valid),
    .cell_index(cell_index),
    .cell_alive(cell_alive),
    .frame_done(frame_done),
    .live_count(live_count),
    .locked(locked),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int gh = 0, gv = 0;
  int mode = 0;
  bit shorten = 1'b0;
  int err_line = 200;
  bit wrapped;

  int npass = 0, ntot = 0;
  int nvalid, nalive, ndone, nerr, nord, nbad;
  int first_idx, a0, a1, lc_seen, lk_err;

  task automatic check(input string tag, input int got, input int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // mode 0: all alive, 1: checkerboard, 2: only board cell 0
  function automatic bit cell_on(input int m, input int r, input int c);
    case (m)
      0:       return 1'b1;
      1:       return ((r ^ c) & 1) == 1;
      2:       return r == 0 && c == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] pix(input int h, input int v);
    int  hs0;
    bit  hsn, vsn, a;
    hs0 = (shorten && v == err_line) ? 574 : HS;
    hsn = !(h >= hs0 && h < HE);
    vsn = !(v >= VS && v < VE);
    a   = h >= 64 && h < 576 && v >= 112 && v < 368 &&
          cell_on(mode, (v >> 3) & 31, (h >> 3) & 63);
    return {hsn, a, a, a, vsn, a, a, a};
  endfunction

  task automatic clear_stats();
    nvalid = 0; nalive = 0; ndone = 0; nerr = 0;
    nord = 0; nbad = 0; first_idx = -1;
    a0 = -1; a1 = -1; lc_seen = -1; lk_err = -1;
  endtask

  task automatic step();
    int ex;
    @(negedge clk);
    if (cell_valid) begin
      ex = ((14 + nvalid / 64) % 32) * 64 + (8 + nvalid % 64) % 64;
      if (int'(cell_index) != ex) nord++;
      if (cell_alive != cell_on(mode, int'(cell_index[10:6]),
                                int'(cell_index[5:0])))
        nbad++;
      if (nvalid == 0) first_idx = int'(cell_index);
      if (cell_index == 11'd0) a0 = int'(cell_alive);
      if (cell_index == 11'd1) a1 = int'(cell_alive);
      if (cell_alive) nalive++;
      nvalid++;
    end
    if (frame_done) begin
      ndone++;
      lc_seen = int'(live_count);
    end
    if (sync_err) begin
      nerr++;
      lk_err = int'(locked);
    end
    vga_in  = pix(gh, gv);
    wrapped = 1'b0;
    gh++;
    if (gh == HT) begin
      gh = 0;
      gv++;
      if (gv == VT) begin
        gv = 0;
        wrapped = 1'b1;
      end
    end
  endtask

  task automatic run_to_wrap();
    do step(); while (!wrapped);
  endtask

  task automatic full_frame_checks(input string tag, input int exp_live);
    check({tag, "_valid"}, nvalid, 2048);
    check({tag, "_order"}, nord, 0);
    check({tag, "_alive"}, nbad, 0);
    check({tag, "_done"}, ndone, 1);
    check({tag, "_done_lc"}, lc_seen, exp_live);
    check({tag, "_live"}, int'(live_count), exp_live);
    check({tag, "_err"}, nerr, 0);
  endtask

  initial begin
    clear_stats();
    reset = 1'b1;
    repeat (4) step();
    check("rst_valid", int'(cell_valid), 0);
    check("rst_index", int'(cell_index), 0);
    check("rst_alive", int'(cell_alive), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_live", int'(live_count), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(sync_err), 0);
    reset = 1'b0;

    // first frame: lock acquired, but nothing captured
    run_to_wrap();
    check("f0_locked", int'(locked), 1);
    check("f0_valid", nvalid, 0);
    check("f0_done", ndone, 0);

    clear_stats();
    run_to_wrap();
    full_frame_checks("all", 2048);
    check("all_first_idx", first_idx, 14 * 64 + 8);

    mode = 1;
    for (int f = 0; f < 2; f++) begin
      clear_stats();
      run_to_wrap();
      full_frame_checks("chk", 1024);
      check("chk_idx0", a0, 0);
      check("chk_idx1", a1, 1);
    end

    mode = 2;
    clear_stats();
    run_to_wrap();
    full_frame_checks("one", 1);
    check("one_nalive", nalive, 1);
    check("one_idx0", a0, 1);

    // a short hsync in the middle of a captured frame
    mode = 0;
    shorten = 1'b1;
    clear_stats();
    run_to_wrap();
    shorten = 1'b0;
    check("hs_err", nerr, 1);
    check("hs_lock_at_err", lk_err, 0);
    check("hs_done", ndone, 0);
    check("hs_live_held", int'(live_count), 1);
    check("hs_relocked", int'(locked), 1);

    clear_stats();
    run_to_wrap();
    full_frame_checks("post_err", 2048);

    // reset in the middle of a captured frame
    mode = 1;
    clear_stats();
    while (gv != 200) step();
    reset = 1'b1;
    step();
    check("mid_rst_live", int'(live_count), 0);
    check("mid_rst_locked", int'(locked), 0);
    check("mid_rst_valid", int'(cell_valid), 0);
    reset = 1'b0;
    run_to_wrap();
    check("mid_rst_done", ndone, 0);
    check("mid_rst_relock", int'(locked), 1);
    check("mid_rst_live0", int'(live_count), 0);

    clear_stats();
    run_to_wrap();
    full_frame_checks("post_rst", 1024);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
